// File: rtl/block_mem_server.sv
// Block-granular backing memory behind an L1 cache: one block read or write per
// transaction, with mem_miss held high for a fixed LATENCY cycles per transaction.
`timescale 1ns/1ps
module block_mem_server #(
  parameter int unsigned BLOCKS  = 8,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [BLOCKS*32-1:0]   mem_write_block,
  output logic [BLOCKS*32-1:0]   mem_read_block,
  output logic                   mem_miss,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  localparam int unsigned BW     = BLOCKS * 32;
  localparam int unsigned OFFW   = $clog2(BLOCKS);
  localparam int unsigned IDXW   = $clog2(DEPTH);
  localparam int unsigned LSB    = OFFW + 2;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              we_q, we_d;
  logic [BW-1:0]     wblk_q, wblk_d;
  logic [BW-1:0]     rblk_q;
  logic [31:0]       rd_cnt_q, wr_cnt_q;
  logic [BW-1:0]     mem_q [DEPTH];

  logic [IDXW-1:0]   req_idx;
  logic              commit;
  logic              commit_we;
  logic [IDXW-1:0]   commit_idx;
  logic [BW-1:0]     commit_blk;
  logic              unused_addr;

  assign req_idx     = mem_addr[IDXW+LSB-1:LSB];
  assign unused_addr = ^{mem_addr[31:IDXW+LSB], mem_addr[LSB-1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    wblk_d     = wblk_q;
    mem_miss   = 1'b0;
    commit     = 1'b0;
    commit_we  = we_q;
    commit_idx = idx_q;
    commit_blk = wblk_q;
    unique case (state_q)
      IDLE: begin
        mem_miss = mem_req;
        if (mem_req) begin
          idx_d  = req_idx;
          we_d   = mem_we;
          wblk_d = mem_write_block;
          // Single-cycle latency commits straight from the live inputs at the accept edge.
          if (LATENCY == 1) begin
            state_d    = DONE;
            commit     = 1'b1;
            commit_we  = mem_we;
            commit_idx = req_idx;
            commit_blk = mem_write_block;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      BUSY: begin
        mem_miss = 1'b1;
        cnt_d    = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wblk_q   <= '0;
      rblk_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wblk_q  <= wblk_d;
      if (commit) begin
        if (commit_we) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
          rblk_q   <= mem_q[commit_idx];
        end
      end
    end
  end

  // Contents survive reset; the reset term only blocks a commit while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
    end else if (commit && commit_we) begin
      mem_q[commit_idx] <= commit_blk;
    end
  end

  assign mem_read_block = rblk_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;

endmodule

// File: tb/tb_block_mem_server.sv
// Bench for block_mem_server: directed table, reset abort, randomized traffic
// against an array model, and a LATENCY=1 instance.
`timescale 1ns/1ps
module tb_block_mem_server;

  localparam int unsigned BLOCKS = 8;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned LAT    = 4;
  localparam int unsigned BW     = BLOCKS * 32;

  typedef logic [BW-1:0] blk_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0;
  blk_t        wdata = '0;
  blk_t        rdblk;
  logic        miss;
  logic [31:0] rdc, wrc;

  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0;
  blk_t        r1_wdata = '0;
  blk_t        r1_rdblk;
  logic        r1_miss;
  logic [31:0] r1_rdc, r1_wrc;

  block_mem_server #(.BLOCKS(BLOCKS), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset), .mem_req(req), .mem_we(we), .mem_addr(addr),
    .mem_write_block(wdata), .mem_read_block(rdblk), .mem_miss(miss),
    .rd_count(rdc), .wr_count(wrc)
  );

  block_mem_server #(.BLOCKS(BLOCKS), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .mem_req(r1_req), .mem_we(r1_we), .mem_addr(r1_addr),
    .mem_write_block(r1_wdata), .mem_read_block(r1_rdblk), .mem_miss(r1_miss),
    .rd_count(r1_rdc), .wr_count(r1_wrc)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: block array, last read block, transaction counters.
  blk_t        mem_m [DEPTH];
  blk_t        exp_rd = '0;
  int unsigned rd_n = 0, wr_n = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic blk_t mk_block(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < BLOCKS; i++) b[i*32 +: 32] = base + 32'h11 * (i + 1);
    return b;
  endfunction

  function automatic blk_t rand_block();
    blk_t b;
    for (int i = 0; i < BLOCKS; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [31:0] rand_addr(input int unsigned idx);
    return ($urandom & 32'hFFFF_0000) | (idx << 5) | ($urandom & 32'h1F);
  endfunction

  // One full transaction on the LATENCY=4 instance, starting at the next edge.
  task automatic txn(input bit t_we, input logic [31:0] t_addr, input blk_t t_data,
                     input bit scramble, input bit done_req);
    int unsigned idx;
    idx = (t_addr >> 5) % DEPTH;
    @(posedge clock); #1;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_data;
    @(negedge clock);
    chk("miss_accept", miss, 1'b1);
    for (int k = 1; k < LAT; k++) begin
      @(posedge clock); #1;
      req = scramble ? 1'($urandom) : 1'b0;
      if (scramble) begin
        addr = $urandom; we = ~t_we; wdata = rand_block();
      end
      @(negedge clock);
      chk("miss_busy", miss, 1'b1);
      chk("rd_hold_busy", rdblk, exp_rd);
    end
    @(posedge clock); #1;
    req = done_req;
    if (t_we) begin
      mem_m[idx] = t_data; wr_n++;
    end else begin
      exp_rd = mem_m[idx]; rd_n++;
    end
    @(negedge clock);
    chk("miss_done", miss, 1'b0);
    chk("rd_block", rdblk, exp_rd);
    chk("rd_count", rdc, rd_n);
    chk("wr_count", wrc, wr_n);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock); #1;
      req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = rand_block();
      @(negedge clock);
      chk("miss_idle", miss, 1'b0);
      chk("rd_hold_idle", rdblk, exp_rd);
      chk("rd_count_idle", rdc, rd_n);
      chk("wr_count_idle", wrc, wr_n);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] base;
    bit          scramble;
    bit          b2b;
    logic [31:0] exp_w0;
    int unsigned exp_rd;
    int unsigned exp_wr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 0, 1};
    tbl[1] = '{1'b0, 32'h0000_011C, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0011, 1, 1};
    tbl[2] = '{1'b1, 32'h0000_0400, 32'h4000_0000, 1'b0, 1'b0, 32'h0000_0011, 1, 2};
    tbl[3] = '{1'b1, 32'h0000_0300, 32'h3000_0000, 1'b0, 1'b0, 32'h0000_0011, 1, 3};
    tbl[4] = '{1'b1, 32'h0000_0200, 32'h2000_0000, 1'b0, 1'b1, 32'h0000_0011, 1, 4};
    tbl[5] = '{1'b0, 32'h0000_0400, 32'h0000_0000, 1'b0, 1'b0, 32'h4000_0011, 2, 4};
    tbl[6] = '{1'b0, 32'h0001_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0011, 3, 4};
    tbl[7] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 1'b0, 32'h2000_0011, 4, 4};
    tbl[8] = '{1'b1, 32'h0000_0100, 32'h5000_0000, 1'b0, 1'b1, 32'h2000_0011, 4, 5};
    tbl[9] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h5000_0011, 5, 5};

    // Reset state, and mem_miss following mem_req while reset is held.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rdblk", rdblk, '0);
    chk("rst_rdc", rdc, 32'd0);
    chk("rst_wrc", wrc, 32'd0);
    chk("rst_miss_lo", miss, 1'b0);
    req = 1'b1; we = 1'b1; wdata = mk_block(32'hDEAD_0000);
    #1 chk("rst_miss_hi", miss, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk("rst_miss_hold", miss, 1'b1);
    chk("rst_wrc_hold", wrc, 32'd0);
    req = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].we, tbl[i].addr, mk_block(tbl[i].base), tbl[i].scramble, tbl[i].b2b);
      chk("tbl_w0", rdblk[31:0], tbl[i].exp_w0);
      chk("tbl_rdc", rdc, tbl[i].exp_rd);
      chk("tbl_wrc", wrc, tbl[i].exp_wr);
      if (!tbl[i].b2b) idle(2);
    end

    // Reset asserted in the second BUSY cycle of a write to 0x300.
    @(posedge clock); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0000_0300; wdata = mk_block(32'h7000_0000);
    @(negedge clock);
    chk("abort_accept", miss, 1'b1);
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    chk("abort_busy1", miss, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("abort_rdblk", rdblk, '0);
    chk("abort_rdc", rdc, 32'd0);
    chk("abort_wrc", wrc, 32'd0);
    chk("abort_miss_lo", miss, 1'b0);
    req = 1'b1;
    #1 chk("abort_miss_follow", miss, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("abort_miss_rst", miss, 1'b1);
    req = 1'b0;
    reset = 1'b1;
    rd_n = 0; wr_n = 0; exp_rd = '0;
    @(negedge clock);
    chk("abort_idle", miss, 1'b0);
    chk("abort_wrc_after", wrc, 32'd0);
    txn(1'b0, 32'h0000_0300, '0, 1'b0, 1'b0);
    chk("abort_prior_w0", rdblk[31:0], 32'h3000_0011);
    chk("abort_wrc_final", wrc, 32'd0);
    idle(1);

    // Randomized traffic over a pool of indices, with aliasing upper bits.
    for (int unsigned p = 0; p < 16; p++) begin
      txn(1'b1, rand_addr(100 + p), rand_block(), 1'b0, 1'($urandom));
    end
    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom), rand_addr(100 + $urandom_range(0, 15)), rand_block(),
          1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // LATENCY=1 instance.
    @(posedge clock); #1;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h0000_0040; r1_wdata = mk_block(32'h6000_0000);
    @(negedge clock);
    chk("l1_wr_miss", r1_miss, 1'b1);
    @(posedge clock); #1;
    r1_req = 1'b0;
    @(negedge clock);
    chk("l1_wr_done", r1_miss, 1'b0);
    chk("l1_wrc", r1_wrc, 32'd1);
    chk("l1_rd_unchanged", r1_rdblk, '0);
    @(posedge clock); #1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h0000_005C;
    @(negedge clock);
    chk("l1_rd_miss", r1_miss, 1'b1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("l1_rd_done", r1_miss, 1'b0);
    chk("l1_rd_data", r1_rdblk, mk_block(32'h6000_0000));
    chk("l1_rdc", r1_rdc, 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("l1_b2b_miss", r1_miss, 1'b1);
    @(posedge clock); #1;
    r1_req = 1'b0;
    @(negedge clock);
    chk("l1_b2b_done", r1_miss, 1'b0);
    chk("l1_rdc2", r1_rdc, 32'd2);
    @(posedge clock); #1;
    @(negedge clock);
    chk("l1_idle", r1_miss, 1'b0);
    chk("l1_rdc_hold", r1_rdc, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
